// File: rtl/regfile_sb_param_if.sv
// Register file bus: read ports, writeback, issue and PC update.
// Master is the core side; slave is the register file.
interface regfile_sb_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              BUSY1;
  logic              BUSY2;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              WE3;
  logic              ISS_EN;
  logic [ADDR_W-1:0] ISS_ADDR;
  logic [DATA_W-1:0] PC_NEXT;
  logic              PC_WE;
  logic [DATA_W-1:0] PC;
  logic              PC_WRITTEN;
  logic              ANY_BUSY;

  modport master (
    output A1, A2, A3, WD3, WE3,
    output ISS_EN, ISS_ADDR,
    output PC_NEXT, PC_WE,
    input  RD1, RD2, BUSY1, BUSY2,
    input  PC, PC_WRITTEN, ANY_BUSY
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3,
    input  ISS_EN, ISS_ADDR,
    input  PC_NEXT, PC_WE,
    output RD1, RD2, BUSY1, BUSY2,
    output PC, PC_WRITTEN, ANY_BUSY
  );
endinterface

// File: rtl/regfile_sb_param.sv
// Register file with PC register and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module regfile_sb_param #(
  parameter int              DATA_W         = 32,
  parameter int              ADDR_W         = 4,
  parameter int              PC_IDX         = 15,
  parameter logic [DATA_W-1:0] PC_READ_OFFSET = DATA_W'(8),
  parameter logic [DATA_W-1:0] RESET_PC       = '0
) (
  input logic               CLK,
  input logic               RST,
  regfile_sb_param_if.slave rf
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic              pc_written_q;
  logic              pc_written_d;

  logic              wb_pc;
  logic [ADDR_W-1:0] ra   [2];
  logic [DATA_W-1:0] rd   [2];
  logic              bsy  [2];

  assign wb_pc = rf.WE3 && (rf.A3 == PC_A);

  // Writeback to PC beats a fetch PC update in the same cycle.
  always_comb begin
    regs_d       = regs_q;
    pend_d       = pend_q;
    pc_d         = pc_q;
    pc_written_d = 1'b0;
    if (rf.WE3 && !wb_pc) begin
      regs_d[rf.A3] = rf.WD3;
      pend_d[rf.A3] = 1'b0;
    end
    if (rf.ISS_EN && (rf.ISS_ADDR != PC_A)) begin
      pend_d[rf.ISS_ADDR] = 1'b1;
    end
    if (wb_pc) begin
      pc_d         = rf.WD3;
      pc_written_d = 1'b1;
    end else if (rf.PC_WE) begin
      pc_d = rf.PC_NEXT;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q       <= '0;
      pc_q         <= RESET_PC;
      pc_written_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      pend_q       <= pend_d;
      pc_q         <= pc_d;
      pc_written_q <= pc_written_d;
    end
  end

  assign ra[0] = rf.A1;
  assign ra[1] = rf.A2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]  = regs_q[ra[p]];
      bsy[p] = pend_q[ra[p]];
      if (ra[p] == PC_A) begin
        rd[p]  = pc_q + PC_READ_OFFSET;
        bsy[p] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (rf.WE3 && (rf.A3 == ra[p])) begin
        rd[p]  = rf.WD3;
        bsy[p] = 1'b0;
      end
`endif
    end
  end

  assign rf.RD1        = rd[0];
  assign rf.RD2        = rd[1];
  assign rf.BUSY1      = bsy[0];
  assign rf.BUSY2      = bsy[1];
  assign rf.PC         = pc_q;
  assign rf.PC_WRITTEN = pc_written_q;
  assign rf.ANY_BUSY   = |pend_q;

endmodule

// File: tb/tb_regfile_sb_param.sv
// Directed and random checks of regfile_sb_param against a reference model.
module tb_regfile_sb_param;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  regfile_sb_param_if #(.DATA_W(32), .ADDR_W(4)) rf ();

  regfile_sb_param dut (
    .CLK (CLK),
    .RST (RST),
    .rf  (rf.slave)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [16];
  logic [15:0] m_pend;
  logic [31:0] m_pc;
  logic        m_pcw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pend = '0;
    m_pc   = '0;
    m_pcw  = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return m_pc + 32'd8;
`ifdef REGFILE_BYPASS_EN
    if (rf.WE3 && rf.A3 == a) return rf.WD3;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rf.WE3 && rf.A3 == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic model_edge();
    logic pc_wb;
    pc_wb = rf.WE3 && rf.A3 == 4'd15;
    m_pcw = pc_wb;
    if (rf.WE3 && !pc_wb) begin
      m_regs[rf.A3] = rf.WD3;
      m_pend[rf.A3] = 1'b0;
    end
    if (pc_wb) m_pc = rf.WD3;
    else if (rf.PC_WE) m_pc = rf.PC_NEXT;
    if (rf.ISS_EN && rf.ISS_ADDR != 4'd15) m_pend[rf.ISS_ADDR] = 1'b1;
  endtask

  task automatic idle();
    rf.A1 = '0; rf.A2 = '0; rf.A3 = '0;
    rf.WD3 = '0; rf.WE3 = 1'b0;
    rf.ISS_EN = 1'b0; rf.ISS_ADDR = '0;
    rf.PC_NEXT = '0; rf.PC_WE = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic chk_all(input string tag);
    #1;
    chk({tag, ".rd1"}, rf.RD1, exp_rd(rf.A1));
    chk({tag, ".busy1"}, 32'(rf.BUSY1), 32'(exp_busy(rf.A1)));
    chk({tag, ".rd2"}, rf.RD2, exp_rd(rf.A2));
    chk({tag, ".busy2"}, 32'(rf.BUSY2), 32'(exp_busy(rf.A2)));
    chk({tag, ".pc"}, rf.PC, m_pc);
    chk({tag, ".pcw"}, 32'(rf.PC_WRITTEN), 32'(m_pcw));
    chk({tag, ".any"}, 32'(rf.ANY_BUSY), 32'(|m_pend));
  endtask

  initial begin
    idle();
    model_reset();
    rf.A1 = 4'd3;
    #2;
    chk("rst_rd1", rf.RD1, 32'h0);
    chk("rst_busy1", 32'(rf.BUSY1), 32'h0);
    chk("rst_pc", rf.PC, 32'h0);
    chk("rst_any", 32'(rf.ANY_BUSY), 32'h0);
    chk("rst_pcw", 32'(rf.PC_WRITTEN), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // PC load and offset read, including wrap
    rf.PC_WE = 1'b1; rf.PC_NEXT = 32'h100;
    step();
    idle(); rf.A1 = 4'd15;
    chk_all("pc1");
    chk("pc1_pc", rf.PC, 32'h100);
    chk("pc1_rd1", rf.RD1, 32'h108);
    chk("pc1_busy1", 32'(rf.BUSY1), 32'h0);
    rf.PC_WE = 1'b1; rf.PC_NEXT = 32'hFFFF_FFFC;
    step();
    idle(); rf.A1 = 4'd15;
    chk_all("pcwrap");
    chk("pcwrap_rd1", rf.RD1, 32'h4);

    // Scoreboard set then clear
    rf.ISS_EN = 1'b1; rf.ISS_ADDR = 4'd5;
    step();
    idle(); rf.A2 = 4'd5;
    chk_all("iss5");
    chk("iss5_busy2", 32'(rf.BUSY2), 32'h1);
    chk("iss5_any", 32'(rf.ANY_BUSY), 32'h1);
    rf.WE3 = 1'b1; rf.A3 = 4'd5; rf.WD3 = 32'hDEAD;
    step();
    idle(); rf.A2 = 4'd5;
    chk_all("wb5");
    chk("wb5_rd2", rf.RD2, 32'hDEAD);
    chk("wb5_busy2", 32'(rf.BUSY2), 32'h0);
    chk("wb5_any", 32'(rf.ANY_BUSY), 32'h0);

    // Simultaneous issue and writeback
    rf.ISS_EN = 1'b1; rf.ISS_ADDR = 4'd7;
    rf.WE3 = 1'b1; rf.A3 = 4'd7; rf.WD3 = 32'h11;
    step();
    idle(); rf.A1 = 4'd7;
    chk_all("sim7");
    chk("sim7_rd1", rf.RD1, 32'h11);
    chk("sim7_busy1", 32'(rf.BUSY1), 32'h1);

    // PC writeback priority over PC_WE
    rf.WE3 = 1'b1; rf.A3 = 4'd15; rf.WD3 = 32'h200;
    rf.PC_WE = 1'b1; rf.PC_NEXT = 32'h300;
    step();
    idle(); rf.A1 = 4'd15;
    chk_all("pcwb");
    chk("pcwb_pc", rf.PC, 32'h200);
    chk("pcwb_pcw", 32'(rf.PC_WRITTEN), 32'h1);
    chk("pcwb_rd1", rf.RD1, 32'h208);
    step();
    rf.A1 = 4'd15;
    chk_all("pcwb2");
    chk("pcwb2_pcw", 32'(rf.PC_WRITTEN), 32'h0);

    // Same-cycle forwarding
    rf.WE3 = 1'b1; rf.A3 = 4'd4; rf.WD3 = 32'h22;
    rf.ISS_EN = 1'b1; rf.ISS_ADDR = 4'd4;
    step();
    idle();
    rf.A1 = 4'd4; rf.WE3 = 1'b1; rf.A3 = 4'd4; rf.WD3 = 32'h55;
    chk_all("byp_pre");
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre_rd1", rf.RD1, 32'h55);
    chk("byp_pre_busy1", 32'(rf.BUSY1), 32'h0);
`else
    chk("byp_pre_rd1", rf.RD1, 32'h22);
    chk("byp_pre_busy1", 32'(rf.BUSY1), 32'h1);
`endif
    step();
    idle(); rf.A1 = 4'd4;
    chk_all("byp_post");
    chk("byp_post_rd1", rf.RD1, 32'h55);
    chk("byp_post_busy1", 32'(rf.BUSY1), 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rf.A1       = 4'($urandom);
      rf.A2       = 4'($urandom);
      rf.A3       = 4'($urandom);
      rf.WD3      = $urandom;
      rf.WE3      = 1'($urandom_range(0, 1));
      rf.ISS_EN   = 1'($urandom_range(0, 1));
      rf.ISS_ADDR = 4'($urandom);
      rf.PC_NEXT  = $urandom;
      rf.PC_WE    = ($urandom_range(0, 3) == 0);
      chk_all("rnd");
      step();
    end

    // Mid-cycle reset with pending bits and a PC_WRITTEN pulse live
    rf.ISS_EN = 1'b1; rf.ISS_ADDR = 4'd3;
    rf.WE3 = 1'b1; rf.A3 = 4'd15; rf.WD3 = 32'h1234;
    step();
    idle(); rf.A1 = 4'd3;
    #2;
    RST = 1'b1;
    model_reset();
    chk_all("mrst");
    chk("mrst_rd1", rf.RD1, 32'h0);
    chk("mrst_pcw", 32'(rf.PC_WRITTEN), 32'h0);
    #1;
    RST = 1'b0;
    rf.WE3 = 1'b1; rf.A3 = 4'd3; rf.WD3 = 32'hA5;
    chk_all("mrst_pre");
    step();
    idle(); rf.A1 = 4'd3;
    chk_all("mrst_post");
    chk("mrst_post_rd1", rf.RD1, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
